// File: rtl/tohost_monitor_if.sv
// Store-snoop bus between the core's data-store path and the tohost monitor.
// The core drives the bus; the monitor only observes it.
interface tohost_monitor_if;
  logic        st_en;
  logic [31:0] st_addr;
  logic [31:0] st_data;

  modport master (output st_en, st_addr, st_data);
  modport slave  (input  st_en, st_addr, st_data);
endinterface

// File: rtl/tohost_monitor.sv
// End-of-test monitor: watches core stores for the riscv-tests tohost write.
// Reports a pass, fail or timeout verdict and the number of RUN cycles taken.
module tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter logic [31:0] TIMEOUT     = 32'd5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  tohost_monitor_if.slave   i_store,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_fail,
  output logic              o_timeout,
  output logic [30:0]       o_failTest,
  output logic [31:0]       o_cycleCount
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  localparam logic [31:0] LP_LAST_CYCLE = TIMEOUT - 32'd1;

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_cycleCount;
  logic [31:0] w_cycleCountNext;
  logic [30:0] r_failTest;
  logic [30:0] w_failTestNext;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic        r_fail;
  logic        r_timeout;
  logic        w_hit;

  assign w_hit = i_store.st_en && (i_store.st_addr == TOHOST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cycleCount <= '0;
      r_failTest   <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_cycleCount <= w_cycleCountNext;
      r_failTest   <= w_failTestNext;
    end
  end

  // Start takes priority over any store in the same cycle; a terminating hit beats the timeout.
  always_comb begin
    w_stateNext      = r_state;
    w_cycleCountNext = r_cycleCount;
    w_failTestNext   = r_failTest;
    case (r_state)
      ST_RUN: begin
        if (i_start) begin
          w_cycleCountNext = '0;
        end else begin
          w_cycleCountNext = r_cycleCount + 32'd1;
          if (w_hit && (i_store.st_data == 32'h1)) begin
            w_stateNext = ST_PASS;
          end else if (w_hit && i_store.st_data[0]) begin
            w_stateNext    = ST_FAIL;
            w_failTestNext = i_store.st_data[31:1];
          end else if (r_cycleCount == LP_LAST_CYCLE) begin
            w_stateNext = ST_TIMEOUT;
          end
        end
      end
      ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (i_start) begin
          w_stateNext      = ST_RUN;
          w_cycleCountNext = '0;
          w_failTestNext   = '0;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Flags are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_busy    <= (w_stateNext == ST_RUN);
      r_done    <= (w_stateNext == ST_PASS) || (w_stateNext == ST_FAIL) ||
                   (w_stateNext == ST_TIMEOUT);
      r_pass    <= (w_stateNext == ST_PASS);
      r_fail    <= (w_stateNext == ST_FAIL);
      r_timeout <= (w_stateNext == ST_TIMEOUT);
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_fail       = r_fail;
  assign o_timeout    = r_timeout;
  assign o_failTest   = r_failTest;
  assign o_cycleCount = r_cycleCount;

endmodule

// File: doc/tohost_monitor.md
Name: tohost_monitor

Overview:
- Synthesizable end-of-test monitor that sits directly downstream of the core's data-store path.
- Snoops every store the core issues and detects the riscv-tests "tohost" handshake write.
- Reports pass, fail with the failing test number, or a watchdog timeout.
- Replaces fixed-tick polling of register x3 in the ISA-test benches with an explicit, cycle-accurate verdict and run-length count.

Parameters:
- TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word; compared on all 32 bits.
- TIMEOUT, 5000, maximum RUN cycles before a timeout verdict; legal range 1..2^32-1.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, single-cycle pulse that begins or restarts a run.
- st_en, input, 1, core store strobe, one store per asserted cycle.
- st_addr, input, 32, store byte address.
- st_data, input, 32, store data, full word.
- busy, output, 1, high while in RUN.
- done, output, 1, high in any terminal state.
- pass, output, 1, high in PASS.
- fail, output, 1, high in FAIL.
- timeout, output, 1, high in TIMEOUT.
- fail_test, output, 31, failing test number, st_data[31:1] of the terminating write.
- cycle_count, output, 32, RUN cycles elapsed.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst rising):
  - State goes to IDLE.
  - busy, done, pass, fail, timeout = 0.
  - fail_test = 0, cycle_count = 0.
- All outputs are registered and decoded from state; no combinational path from inputs to outputs.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT.
- IDLE:
  - Stores are ignored.
  - start=1 moves to RUN next edge; cycle_count cleared to 0, fail_test cleared to 0.
- RUN:
  - cycle_count increments by 1 every cycle.
  - A tohost hit is st_en=1 and st_addr==TOHOST_ADDR. On a hit:
    - st_data==32'h1 -> PASS.
    - st_data[0]==1 and st_data!=1 -> FAIL; fail_test <= st_data[31:1].
    - st_data[0]==0 (syscall/proxy request) -> ignored, remain in RUN.
  - Stores to any other address have no effect.
  - If no terminating hit occurs and cycle_count==TIMEOUT-1 -> TIMEOUT; cycle_count still increments that edge, so it reads TIMEOUT in the terminal state.
  - Verdict latency: the terminal state and flags are visible the cycle after the hit edge. cycle_count freezes at the value including the hit cycle.
- Simultaneous events:
  - A terminating hit on the same cycle as the timeout condition -> the hit wins (PASS/FAIL, not TIMEOUT).
  - start=1 while in RUN -> restart: cycle_count <= 0, stay in RUN; any store that cycle is ignored.
- Terminal states (PASS/FAIL/TIMEOUT):
  - Sticky; further stores ignored; cycle_count and fail_test hold.
  - start=1 -> RUN with counters cleared as from IDLE.
- Exactly one of busy/pass/fail/timeout is high outside IDLE. done = pass|fail|timeout.
- cycle_count is 32-bit; with TIMEOUT<=2^32-1 it never wraps.
- Reset asserted mid-run aborts immediately to IDLE with all outputs 0; start is not accepted while rst is high.

Test Plan:
1. Pass: rst, start pulse, 20 idle cycles, store 32'h1 to 32'h1000 -> next cycle pass=1, done=1, busy=0, cycle_count=21, fail_test=0.
2. Fail: start, store 32'h7 to 32'h1000 at cycle 5 -> fail=1, fail_test=3, cycle_count=6. Later stores of 1 to 32'h1000 do not change the verdict.
3. Ignored traffic: in RUN, store 32'h1 to 32'h1004 and 32'h2 to 32'h1000 -> remain busy=1. Then store 1 to 32'h1000 -> pass.
4. Timeout: TIMEOUT=16, start, no tohost stores -> timeout=1 after 16 RUN cycles, cycle_count=16. Separately, a pass store on cycle 15 -> pass=1, not timeout.
5. Restart/reset: start again during RUN at cycle 10 -> cycle_count restarts at 0. Assert rst asynchronously mid-run (between edges) -> all outputs 0 immediately; a later start runs normally.
6. Restart from terminal: after FAIL, pulse start -> busy=1, fail=0, fail_test=0, cycle_count counts from 0.
